dot_product_ctrl: RTL and testbench

//  Sequencer for the dotProduct datapath. On a start pulse it streams VETOR_WIDTH element

---
 rtl/dot_product_pkg.sv | 37 +++
 rtl/dot_mac.sv | 47 ++++
 rtl/dot_product_ctrl.sv | 141 ++++++++++++++
 tb/tb_dot_product_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_product_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dot_product_pkg                                              |
// | Description : Shared definitions for the dot-product sequencer: a constant |
// |               clog2 helper, the accumulator width derivation, and the     |
// |               sequencer FSM state encoding.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package dot_product_pkg;

   // Ceiling log2 for elaboration-time width derivation (clog2(1) = 0).
   function automatic int clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result    = result + 1;
         remaining = remaining >> 1;
      end
      return result;
   endfunction

   // Sum of VETOR_WIDTH unsigned DATA_WIDTH x DATA_WIDTH products cannot
   // exceed 2*DATA_WIDTH + clog2(VETOR_WIDTH) bits.
   function automatic int acc_width(input int data_width, input int vetor_width);
      return 2 * data_width + clog2(vetor_width);
   endfunction

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/dot_mac.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dot_mac                                                      |
// | Description : Registered unsigned multiply-accumulate.                     |
// |               clr zeroes the accumulator (priority over en); en adds a*b.  |
// |               sum exposes acc + a*b combinationally so the sequencer can   |
// |               capture the final total on the same edge as the last add.    |
// | Ports       : clk, rst_n (async active-low), clr, en, a, b -> acc, sum     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dot_mac #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 18
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [ACC_WIDTH-1:0]  acc,
   output logic [ACC_WIDTH-1:0]  sum
);

   logic [2*DATA_WIDTH-1:0] w_prod;
   logic [ACC_WIDTH-1:0]    w_sum;
   logic [ACC_WIDTH-1:0]    r_acc;

   // Operands widened first so the full-width product is kept.
   assign w_prod = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
   assign w_sum  = r_acc + ACC_WIDTH'(w_prod);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
      end else if (clr) begin
         r_acc <= '0;
      end else if (en) begin
         r_acc <= w_sum;
      end
   end

   assign acc = r_acc;
   assign sum = w_sum;

endmodule
`default_nettype wire

// File: rtl/dot_product_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dot_product_ctrl                                             |
// | Description : Sequencer for the dot-product datapath. On an accepted start |
// |               it issues VETOR_WIDTH consecutive reads to memories A and B  |
// |               (addresses wrap), multiply-accumulates the returned pairs    |
// |               and presents the sum with a one-cycle done pulse.            |
// | Ports       : clk, rst_n        clock, async active-low reset             |
// |               start, base_a/b   request and vector base addresses         |
// |               a/b_rd_en, a/b_rd_addr, a/b_data   memory read ports         |
// |               busy, done, result                 status and result         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dot_product_ctrl
   import dot_product_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int VETOR_WIDTH = 4,
   parameter int DEPTH       = VETOR_WIDTH * DATA_WIDTH,
   parameter int ADDR_WIDTH  = clog2(DEPTH),
   parameter int ACC_WIDTH   = acc_width(DATA_WIDTH, VETOR_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_a,
   input  logic [ADDR_WIDTH-1:0] base_b,
   output logic                  a_rd_en,
   output logic [ADDR_WIDTH-1:0] a_rd_addr,
   input  logic [DATA_WIDTH-1:0] a_data,
   output logic                  b_rd_en,
   output logic [ADDR_WIDTH-1:0] b_rd_addr,
   input  logic [DATA_WIDTH-1:0] b_data,
   output logic                  busy,
   output logic                  done,
   output logic [ACC_WIDTH-1:0]  result
);

   localparam int IDX_WIDTH = (VETOR_WIDTH > 1) ? clog2(VETOR_WIDTH) : 1;
   localparam logic [IDX_WIDTH-1:0] c_last_idx = IDX_WIDTH'(VETOR_WIDTH - 1);

   state_t                r_state;
   logic [IDX_WIDTH-1:0]  r_idx;
   logic                  r_rd_en;
   logic                  r_pipe_vld;
   logic [ADDR_WIDTH-1:0] r_a_addr;
   logic [ADDR_WIDTH-1:0] r_b_addr;
   logic                  r_busy;
   logic                  r_done;
   logic [ACC_WIDTH-1:0]  r_result;

   logic                  w_accept;
   logic [ACC_WIDTH-1:0]  w_acc;
   logic [ACC_WIDTH-1:0]  w_sum;

   assign w_accept = (r_state == S_IDLE) && start;

   // Memory data lags the read edge by one cycle, so r_pipe_vld (rd_en
   // delayed) marks cycles where a_data/b_data hold a pair to accumulate.
   dot_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_accept),
      .en    (r_pipe_vld),
      .a     (a_data),
      .b     (b_data),
      .acc   (w_acc),
      .sum   (w_sum)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_rd_en    <= 1'b0;
         r_pipe_vld <= 1'b0;
         r_a_addr   <= '0;
         r_b_addr   <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_result   <= '0;
      end else begin
         r_pipe_vld <= r_rd_en;
         r_done     <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state  <= S_ISSUE;
                  r_idx    <= '0;
                  r_rd_en  <= 1'b1;
                  r_a_addr <= base_a;
                  r_b_addr <= base_b;
                  r_busy   <= 1'b1;
               end
            end
            S_ISSUE: begin
               // The read for the current index is on the bus this cycle;
               // either step to the next pair or stop after the last one.
               if (r_idx == c_last_idx) begin
                  r_rd_en <= 1'b0;
                  r_state <= S_DRAIN;
               end else begin
                  r_idx    <= r_idx + IDX_WIDTH'(1);
                  r_a_addr <= r_a_addr + ADDR_WIDTH'(1);
                  r_b_addr <= r_b_addr + ADDR_WIDTH'(1);
               end
            end
            S_DRAIN: begin
               // Last pair is on the data bus: capture acc + final product.
               if (r_pipe_vld) begin
                  r_result <= w_sum;
                  r_done   <= 1'b1;
                  r_busy   <= 1'b0;
                  r_state  <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign a_rd_en   = r_rd_en;
   assign b_rd_en   = r_rd_en;
   assign a_rd_addr = r_a_addr;
   assign b_rd_addr = r_b_addr;
   assign busy      = r_busy;
   assign done      = r_done;
   assign result    = r_result;

   // Running accumulator is only consumed through sum; keep it observable
   // for hierarchy probes without leaving an unused-signal hole.
   logic w_acc_unused;
   assign w_acc_unused = ^w_acc;

endmodule
`default_nettype wire

// File: tb/tb_dot_product_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dot_product_ctrl                                          |
// | Description : Self-checking bench for dot_product_ctrl with two behavioural|
// |               read-latency-1 memories, a scoreboard of expected reads and  |
// |               results, and a sum(A[i]*B[i]) reference model.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dot_product_ctrl;

   localparam int DW    = 8;
   localparam int VW    = 4;
   localparam int DEPTH = VW * DW;
   localparam int AW    = 5;
   localparam int ACCW  = 18;

   logic            clk;
   logic            rst_n;
   logic            start;
   logic [AW-1:0]   base_a;
   logic [AW-1:0]   base_b;
   logic            a_rd_en;
   logic [AW-1:0]   a_rd_addr;
   logic [DW-1:0]   a_data;
   logic            b_rd_en;
   logic [AW-1:0]   b_rd_addr;
   logic [DW-1:0]   b_data;
   logic            busy;
   logic            done;
   logic [ACCW-1:0] result;

   logic [DW-1:0] mem_a [DEPTH];
   logic [DW-1:0] mem_b [DEPTH];

   typedef struct {
      int unsigned res;
      int          cyc;
   } res_exp_t;

   typedef struct {
      int a;
      int b;
      int cyc;
   } rd_exp_t;

   res_exp_t res_q[$];
   rd_exp_t  rd_q[$];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   dot_product_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_a    (base_a),
      .base_b    (base_b),
      .a_rd_en   (a_rd_en),
      .a_rd_addr (a_rd_addr),
      .a_data    (a_data),
      .b_rd_en   (b_rd_en),
      .b_rd_addr (b_rd_addr),
      .b_data    (b_data),
      .busy      (busy),
      .done      (done),
      .result    (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Read-latency-1 memories.
   always @(posedge clk) begin
      if (a_rd_en) a_data <= mem_a[a_rd_addr];
      if (b_rd_en) b_data <= mem_b[b_rd_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks   = checks + 1;
      failures = failures + 1;
      $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
   endtask

   // Reference: expected reads and dot product for an op accepted at the
   // posedge that ends cycle c.
   task automatic push_exp(input int ba, input int bb, input int c);
      int unsigned total;
      total = 0;
      for (int k = 0; k < VW; k++) begin
         total = total + int'(mem_a[(ba + k) % DEPTH]) * int'(mem_b[(bb + k) % DEPTH]);
         rd_q.push_back('{a: (ba + k) % DEPTH, b: (bb + k) % DEPTH, cyc: c + 1 + k});
      end
      res_q.push_back('{res: total, cyc: c + VW + 2});
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Issue one start pulse while the DUT is idle; bases are scrambled after
   // the accept edge.
   task automatic issue(input int ba, input int bb);
      start  = 1'b1;
      base_a = AW'(ba);
      base_b = AW'(bb);
      push_exp(ba, bb, cyc);
      idle(1);
      start  = 1'b0;
      base_a = AW'($urandom);
      base_b = AW'($urandom);
   endtask

   task automatic fill_random();
      for (int i = 0; i < DEPTH; i++) begin
         mem_a[i] = DW'($urandom);
         mem_b[i] = DW'($urandom);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_a_rd_en"}, 32'(a_rd_en), 0);
      check({tag, "_b_rd_en"}, 32'(b_rd_en), 0);
      check({tag, "_a_rd_addr"}, 32'(a_rd_addr), 0);
      check({tag, "_b_rd_addr"}, 32'(b_rd_addr), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_result"}, 32'(result), 0);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a read or a done.
   always @(negedge clk) begin
      if (rst_n) begin
         check("b_rd_en_tracks_a", 32'(b_rd_en), 32'(a_rd_en));
         if (a_rd_en) begin
            if (rd_q.size() == 0) begin
               fail_now("spurious_read");
            end else begin
               rd_exp_t e;
               e = rd_q.pop_front();
               check("read_cycle", 32'(cyc), 32'(e.cyc));
               check("a_rd_addr", 32'(a_rd_addr), 32'(e.a));
               check("b_rd_addr", 32'(b_rd_addr), 32'(e.b));
               check("busy_during_read", 32'(busy), 1);
            end
         end
         if (done) begin
            if (res_q.size() == 0) begin
               fail_now("spurious_done");
            end else begin
               res_exp_t r;
               r = res_q.pop_front();
               check("done_cycle", 32'(cyc), 32'(r.cyc));
               check("result", 32'(result), r.res);
               check("busy_at_done", 32'(busy), 0);
            end
         end
      end
   end

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      base_a = '0;
      base_b = '0;
      for (int i = 0; i < DEPTH; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
      idle(2);
      check_all_zero("reset");
      rst_n = 1'b1;
      idle(2);

      // Small known vectors at base 0/0.
      for (int i = 0; i < VW; i++) begin
         mem_a[i] = DW'(i + 1);
         mem_b[i] = DW'(i + 5);
      end
      issue(0, 0);
      idle(VW + 1);

      // Full-scale operands.
      for (int i = 0; i < DEPTH; i++) begin
         mem_a[i] = '1;
         mem_b[i] = '1;
      end
      issue(7, 19);
      idle(VW + 3);

      // Address wrap on A.
      fill_random();
      issue(30, 2);
      idle(VW + 1);

      // Extra start pulses while busy must be ignored.
      fill_random();
      issue(11, 12);
      start = 1'b1;
      idle(1);
      start = 1'b0;
      idle(VW - 2);
      start = 1'b1;
      idle(1);
      start = 1'b0;
      idle(2);

      // Reset in the middle of the issue phase.
      fill_random();
      issue(4, 9);
      idle(1);
      rst_n = 1'b0;
      res_q.delete();
      rd_q.delete();
      #1;
      check_all_zero("abort");
      idle(2);
      rst_n = 1'b1;
      idle(3);
      issue(20, 28);
      idle(VW + 1);

      // Start held high through the done cycle: back-to-back ops.
      fill_random();
      start  = 1'b1;
      base_a = AW'(5);
      base_b = AW'(29);
      push_exp(5, 29, cyc);
      idle(VW + 2);
      push_exp(5, 29, cyc);
      idle(1);
      start = 1'b0;
      idle(VW + 2);

      // Randomised operations with random gaps.
      for (int n = 0; n < 20; n++) begin
         fill_random();
         issue(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)));
         idle(VW + 1 + int'($urandom_range(0, 3)));
      end

      idle(10);
      check("pending_results", 32'(res_q.size()), 0);
      check("pending_reads", 32'(rd_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
